// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bundle for imem_loader.
// Ports: Byte_In/Byte_Valid/Byte_Ready host stream; Mem_Wr_En/Addr/Data memory write port.
// Latency: none (wires only). Backpressure: Byte_Ready driven by the loader.
interface imem_loader_if #(
  parameter int DWIDTH = 32
);
  logic [7:0]        Byte_In;
  logic              Byte_Valid;
  logic              Byte_Ready;
  logic              Mem_Wr_En;
  logic [DWIDTH-1:0] Mem_Wr_Addr;
  logic [31:0]       Mem_Wr_Data;

  // Host / memory side.
  modport master (
    output Byte_In, Byte_Valid,
    input  Byte_Ready, Mem_Wr_En, Mem_Wr_Addr, Mem_Wr_Data
  );

  // Loader side.
  modport slave (
    input  Byte_In, Byte_Valid,
    output Byte_Ready, Mem_Wr_En, Mem_Wr_Addr, Mem_Wr_Data
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses A5/count/data/xor-checksum frames into imem word writes, gates core reset.
// Latency: write strobe 1 cycle after a word's 4th byte; status 1 cycle after the deciding byte.
// Backpressure: none; Byte_Ready is 1 in every state after reset, so bytes may arrive every cycle.
// Ports: Clk_Core, Rst_Core (sync, active-high); bus (slave: byte stream in, memory write out);
//        Core_Hold (core reset), Load_Done (frame verified), Load_Error (frame aborted).
module imem_loader #(
  parameter int         DWIDTH      = 32,
  parameter int         MEM_SIZE    = 16384,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 1000000
) (
  input  logic         Clk_Core,
  input  logic         Rst_Core,
  imem_loader_if.slave bus,
  output logic         Core_Hold,
  output logic         Load_Done,
  output logic         Load_Error
);

  // One extra bit so a count of exactly MEM_SIZE does not wrap the word index.
  localparam int IDX_W = $clog2(MEM_SIZE) + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [2:0] {
    IDLE, CNT_LO, CNT_HI, DATA, CSUM, DONE, ERROR
  } state_t;

  state_t            state_q, state_d;
  logic              rdy_q;
  logic              wr_en_q, wr_en_d;
  logic [DWIDTH-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]  widx_q, widx_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        csum_q, csum_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  logic        acc;
  logic        in_frame;
  logic        go_err;
  logic [15:0] n_words;

  assign acc = bus.Byte_Valid && rdy_q;
  assign in_frame = (state_q == CNT_LO) || (state_q == CNT_HI) ||
                    (state_q == DATA)   || (state_q == CSUM);

  always_comb begin
    state_d = state_q;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    bidx_d  = bidx_q;
    word_d  = word_q;
    csum_d  = csum_q;
    tmo_d   = '0;
    go_err  = 1'b0;
    n_words = {bus.Byte_In, cnt_q[7:0]};

    // Inter-byte idle watchdog, only meaningful while a frame is open.
    if (in_frame && !acc) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) go_err = 1'b1;
      else                                  tmo_d  = tmo_q + 1'b1;
    end

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (acc && bus.Byte_In == SYNC_BYTE) begin
          state_d = CNT_LO;
          done_d  = 1'b0;
          err_d   = 1'b0;
          hold_d  = 1'b1;
          widx_d  = '0;
          bidx_d  = '0;
          csum_d  = '0;
        end
      end
      CNT_LO: begin
        if (acc) begin
          cnt_d[7:0] = bus.Byte_In;
          state_d    = CNT_HI;
        end
      end
      CNT_HI: begin
        if (acc) begin
          cnt_d = n_words;
          if ({16'h0, n_words} > 32'(MEM_SIZE)) go_err  = 1'b1;
          else if (n_words == 16'h0)            state_d = CSUM;
          else                                  state_d = DATA;
        end
      end
      DATA: begin
        if (acc) begin
          word_d[{bidx_q, 3'b000} +: 8] = bus.Byte_In;
          csum_d = csum_q ^ bus.Byte_In;
          bidx_d = bidx_q + 1'b1;
          if (bidx_q == 2'd3) begin
            wr_en_d = 1'b1;
            addr_d  = DWIDTH'({widx_q, 2'b00});
            data_d  = word_d;
            widx_d  = widx_q + 1'b1;
            if ((32'(widx_q) + 32'd1) == 32'(cnt_q)) state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (acc) begin
          if (bus.Byte_In == csum_q) begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b0;
            hold_d  = 1'b0;
          end else begin
            go_err = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (go_err) begin
      state_d = ERROR;
      err_d   = 1'b1;
      done_d  = 1'b0;
      hold_d  = 1'b1;
    end
  end

  // Reset wins over everything, including a write decided in the same cycle.
  always_ff @(posedge Clk_Core) begin
    if (Rst_Core) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      word_q  <= '0;
      csum_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.Byte_Ready  = rdy_q;
  assign bus.Mem_Wr_En   = wr_en_q;
  assign bus.Mem_Wr_Addr = addr_q;
  assign bus.Mem_Wr_Data = data_q;
  assign Core_Hold       = hold_q;
  assign Load_Done       = done_q;
  assign Load_Error      = err_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory. It receives a framed byte stream from the host link (UART RX or debug bridge) over a valid/ready handshake.
- It assembles little-endian 32-bit words and drives the instruction memory write port with byte addresses in the same format the core uses for Program_Count.
- It holds the core in reset until a frame has loaded and its checksum has been verified.

Parameters:
DWIDTH, 32, width of Mem_Wr_Addr (byte address; bits [1:0] always 0)
MEM_SIZE, 16384, instruction memory depth in words; largest legal word count
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYC, 1000000, idle cycles allowed between bytes inside a frame before the load aborts

Ports:
Clk_Core  input  1  core clock
Rst_Core  input  1  reset; synchronous, active-high
Byte_In  input  8  incoming stream byte
Byte_Valid  input  1  Byte_In is valid
Byte_Ready  output  1  loader accepts a byte; transfer occurs when Byte_Valid && Byte_Ready
Mem_Wr_En  output  1  one-cycle instruction memory write strobe
Mem_Wr_Addr  output  DWIDTH  byte address of the word being written
Mem_Wr_Data  output  32  instruction word
Core_Hold  output  1  holds the core in reset while high
Load_Done  output  1  last frame loaded and checksum verified
Load_Error  output  1  last frame aborted (oversize count, bad checksum, timeout)

Behaviour:
- One clock, Clk_Core. Rst_Core is synchronous and active-high.
- Reset values: state IDLE, Byte_Ready 0, Mem_Wr_En 0, Mem_Wr_Addr 0, Mem_Wr_Data 0, Core_Hold 1, Load_Done 0, Load_Error 0. Byte_Ready goes to 1 on the first cycle after reset and stays 1 in every state.
- Frame format: SYNC_BYTE, CNT_LO, CNT_HI, then 4*N data bytes (N = {CNT_HI,CNT_LO}, each word LSB first), then CSUM. CSUM is the XOR of all data bytes.
- State machine, advancing only on accepted bytes unless noted:
  - IDLE/DONE/ERROR: SYNC_BYTE -> CNT_LO. Any other byte is discarded and the state is unchanged.
  - Accepting SYNC_BYTE clears Load_Done and Load_Error and sets Core_Hold=1 on the next cycle. It also clears the word index, byte index and checksum accumulator.
  - CNT_LO -> CNT_HI.
  - CNT_HI: if N > MEM_SIZE -> ERROR. If N == 0 -> CSUM. Otherwise -> DATA.
  - DATA: shift the byte into the word register at the current byte index and XOR it into the checksum.
    - On the 4th byte, the next cycle has Mem_Wr_En=1, Mem_Wr_Addr={word_idx,2'b00}, Mem_Wr_Data=assembled word; word_idx then increments.
    - After word N-1's 4th byte -> CSUM.
  - CSUM: byte == accumulator -> DONE, else -> ERROR.
  - DONE: Load_Done=1, Core_Hold=0.
  - ERROR: Load_Error=1, Core_Hold=1. Words already written stay in memory and are not rolled back.
- Latency: 1 cycle from acceptance of a word's 4th byte to Mem_Wr_En. Back-to-back bytes on every cycle are supported, so writes can be separated by as few as 4 cycles.
- Timeout: a counter runs in CNT_LO, CNT_HI, DATA and CSUM. It clears on every accepted byte. When it reaches TIMEOUT_CYC-1 with no accepted byte -> ERROR. The counter is inactive in IDLE, DONE and ERROR.
- Word index width is clog2(MEM_SIZE)+1 so that N == MEM_SIZE does not wrap. The last address written is (MEM_SIZE-1)*4.
- SYNC_BYTE has no special meaning inside a frame; it is treated as count, data or checksum.
- Rst_Core during a frame aborts it immediately to the reset values. No further Mem_Wr_En is issued, including for a word whose 4th byte was accepted in the reset cycle.
- Load_Done and Load_Error are never both 1.

Test Plan:
1. Reset, then frame A5 02 00 13 05 C0 00 EF 00 C0 00 CS with CS=XOR of the 8 data bytes -> two writes: (addr 0x0, data 0x00C00513) and (addr 0x4, data 0x00C000EF). Then Load_Done=1, Core_Hold=0 and Load_Error=0.
2. Same frame with CS xor 0x01 -> both writes occur, then Load_Error=1, Core_Hold=1, Load_Done=0. A correct frame sent next -> Load_Done=1.
3. Count bytes 01 40 (N=16385) with MEM_SIZE=16384 -> ERROR immediately after CNT_HI with no writes. Count 00 40 with 65536 back-to-back data bytes -> last write at addr 0xFFFC.
4. Garbage 00 FF 13 before A5, then a count of 0 and CSUM 00 -> garbage is ignored, no writes, Load_Done=1. A5 sent while in DONE -> Core_Hold returns to 1 the next cycle.
5. TIMEOUT_CYC=16: A5 01 00 13 05, then Byte_Valid held low -> Load_Error=1 exactly 16 cycles after the last accepted byte, with no write.
6. Rst_Core pulsed for 1 cycle after the 3rd data byte of a word -> all outputs take their reset values, no Mem_Wr_En is issued, and a fresh full frame then loads correctly.
